// File: rtl/io_pkg.sv
// Shared definitions for the board I/O ports: data width, debounce FSM states
// and the default debounce length used by switch (and future button) inputs.
package io_pkg;

    localparam int unsigned SW_WIDTH                = 8;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } debounce_state_t;

endpackage

// File: rtl/sync2_ff.sv
// Generic two-flop synchroniser for asynchronous level inputs, with
// asynchronous active-high reset to zero.
module sync2_ff #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/switch_input_port.sv
// Debounced 8-bit switch read port with sticky change flag cleared on read.
// Optional SWITCH_INPUT_PORT_RISE_CAPTURE_EN adds sticky per-bit rise flags.
module switch_input_port
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw_in,
    input  logic                rd_en,
    output logic [SW_WIDTH-1:0] rd_data,
    output logic [SW_WIDTH-1:0] stable,
    output logic                changed
`ifdef SWITCH_INPUT_PORT_RISE_CAPTURE_EN
    ,
    output logic [SW_WIDTH-1:0] rise_flags
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sync_q;
    logic [SW_WIDTH-1:0] candidate, candidate_n;
    logic [CNT_W-1:0]    counter, counter_n;
    logic [SW_WIDTH-1:0] stable_n;
    logic [SW_WIDTH-1:0] rd_data_n;
    logic                changed_n;
    logic                accept;
    debounce_state_t     state, state_n;

    sync2_ff #(
        .WIDTH(SW_WIDTH)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (sw_in),
        .q  (sync_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            candidate <= '0;
            counter   <= '0;
            stable    <= '0;
            rd_data   <= '0;
            changed   <= 1'b0;
        end else begin
            state     <= state_n;
            candidate <= candidate_n;
            counter   <= counter_n;
            stable    <= stable_n;
            rd_data   <= rd_data_n;
            changed   <= changed_n;
        end
    end

    always_comb begin
        state_n     = state;
        candidate_n = candidate;
        counter_n   = counter;
        stable_n    = stable;
        accept      = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync_q != stable) begin
                    candidate_n = sync_q;
                    counter_n   = '0;
                    state_n     = COUNT;
                end
            end
            COUNT: begin
                if (sync_q != candidate) begin
                    candidate_n = sync_q;
                    counter_n   = '0;
                end else if (counter != CNT_LAST) begin
                    counter_n = counter + CNT_W'(1);
                end else begin
                    accept   = 1'b1;
                    stable_n = candidate;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Read captures the pre-edge stable value; a same-edge update re-sets the flag.
    always_comb begin
        rd_data_n = rd_en ? stable : rd_data;
        changed_n = rd_en ? 1'b0 : changed;
        if (accept && (candidate != stable))
            changed_n = 1'b1;
    end

`ifdef SWITCH_INPUT_PORT_RISE_CAPTURE_EN
    logic [SW_WIDTH-1:0] rise_n;

    always_comb begin
        rise_n = rd_en ? '0 : rise_flags;
        if (accept)
            rise_n = rise_n | (candidate & ~stable);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rise_flags <= '0;
        else
            rise_flags <= rise_n;
    end
`endif

endmodule

// File: tb/tb_switch_input_port.sv
// Directed self-checking bench for switch_input_port with DEBOUNCE_CYCLES=4:
// a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_switch_input_port;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sw_in = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic [7:0] stable;
    logic       changed;
`ifdef SWITCH_INPUT_PORT_RISE_CAPTURE_EN
    logic [7:0] rise_flags;
`endif

    int unsigned total  = 0;
    int unsigned passed = 0;

    switch_input_port #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .rd_en  (rd_en),
        .rd_data(rd_data),
        .stable (stable),
        .changed(changed)
`ifdef SWITCH_INPUT_PORT_RISE_CAPTURE_EN
        ,
        .rise_flags(rise_flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sw;
        logic       rd;
        logic [7:0] exp_stable;
        logic       exp_changed;
        logic [7:0] exp_rd_data;
    } vec_t;

    vec_t        vecs[64];
    int unsigned nvec = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] sw, input logic rd, input logic [7:0] st,
                       input logic ch, input logic [7:0] rdd);
        vecs[nvec] = '{sw, rd, st, ch, rdd};
        nvec++;
    endtask

    // Drive a new level and let it qualify (7 edges), then read to clear changed.
    task automatic settle(input logic [7:0] val);
        sw_in = val;
        repeat (7) tick();
        chk("settle_stable", stable, val);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("settle_rd_data", rd_data, val);
        chk("settle_changed", {7'd0, changed}, 8'h00);
    endtask

    initial begin
        // Reset asserted mid-cycle with switches high.
        sw_in = 8'hFF;
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("reset_stable", stable, 8'h00);
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_changed", {7'd0, changed}, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("rst_rel_stable_e%0d", e), stable, (e == 7) ? 8'hFF : 8'h00);
            chk($sformatf("rst_rel_changed_e%0d", e), {7'd0, changed}, (e == 7) ? 8'h01 : 8'h00);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rst_read_rd_data", rd_data, 8'hFF);
        chk("rst_read_changed", {7'd0, changed}, 8'h00);

        // Clean steps FF->00->A5 with reads, including a held read strobe.
        for (int i = 1; i <= 6; i++) add(8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF);
        add(8'h00, 1'b0, 8'h00, 1'b1, 8'hFF);
        add(8'h00, 1'b1, 8'h00, 1'b0, 8'h00);
        for (int i = 1; i <= 6; i++) add(8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);
        add(8'hA5, 1'b0, 8'hA5, 1'b1, 8'h00);
        add(8'hA5, 1'b1, 8'hA5, 1'b0, 8'hA5);
        add(8'hA5, 1'b1, 8'hA5, 1'b0, 8'hA5);
        add(8'hA5, 1'b0, 8'hA5, 1'b0, 8'hA5);
        add(8'hA5, 1'b0, 8'hA5, 1'b0, 8'hA5);
        for (int i = 0; i < int'(nvec); i++) begin
            sw_in = vecs[i].sw;
            rd_en = vecs[i].rd;
            tick();
            chk($sformatf("vec%0d_stable", i), stable, vecs[i].exp_stable);
            chk($sformatf("vec%0d_changed", i), {7'd0, changed}, {7'd0, vecs[i].exp_changed});
            chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd_data);
        end
        rd_en = 1'b0;

        // Bounce: 01/00 every 2 cycles for 20 cycles, then hold 01.
        settle(8'h00);
        for (int c = 0; c < 20; c++) begin
            sw_in = ((c / 2) % 2 == 0) ? 8'h01 : 8'h00;
            tick();
            chk($sformatf("bounce_stable_c%0d", c), stable, 8'h00);
        end
        sw_in = 8'h01;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("bounce_hold_stable_e%0d", e), stable, (e == 7) ? 8'h01 : 8'h00);
        end
        chk("bounce_changed", {7'd0, changed}, 8'h01);

        // Glitch back to the old value: no update, no change flag.
        settle(8'h00);
        sw_in = 8'h10;
        repeat (3) tick();
        sw_in = 8'h00;
        for (int e = 0; e < 14; e++) begin
            tick();
            chk($sformatf("glitch_stable_e%0d", e), stable, 8'h00);
            chk($sformatf("glitch_changed_e%0d", e), {7'd0, changed}, 8'h00);
        end

        // Read on the same edge as an update 0F->F0.
        settle(8'h0F);
        sw_in = 8'hF0;
        repeat (6) tick();
        chk("coll_pre_stable", stable, 8'h0F);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("coll_rd_data", rd_data, 8'h0F);
        chk("coll_changed", {7'd0, changed}, 8'h01);
        chk("coll_stable", stable, 8'hF0);
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("coll_next_rd_data", rd_data, 8'hF0);
        chk("coll_next_changed", {7'd0, changed}, 8'h00);

`ifdef SWITCH_INPUT_PORT_RISE_CAPTURE_EN
        chk("rise_after_coll_read", rise_flags, 8'h00);
        settle(8'h0F);
        chk("rise_cleared_0F", rise_flags, 8'h00);
        sw_in = 8'h3C;
        repeat (7) tick();
        chk("rise_stable_3C", stable, 8'h3C);
        chk("rise_flags_30", rise_flags, 8'h30);
        tick();
        chk("rise_sticky", rise_flags, 8'h30);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rise_cleared", rise_flags, 8'h00);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
